// File: rtl/cu_seq.sv
// cu_seq: parametrised instruction-cycle sequencer.
// Steps each instruction through fetch, decode, execute and an optional memory
// phase using cs/ready handshakes. It routes execute to one of N_EU channels,
// supports free-run and single-step, halts on handshake timeout, illegal
// channel select or stray execute ready, and counts retired instructions.
module cu_seq #(
    parameter int N_EU    = 2,
    parameter int SEL_W   = 1,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             go,
    output logic             cs_fcu,
    input  logic             ready_fcu,
    output logic             cs_dec,
    input  logic             ready_dec,
    input  logic [SEL_W-1:0] dec_eu_sel,
    input  logic             dec_mem,
    output logic [N_EU-1:0]  cs_eu,
    input  logic [N_EU-1:0]  ready_eu,
    output logic             cs_biu,
    input  logic             ready_biu,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [1:0]      ERR_TIMEOUT = 2'b01;
    localparam logic [1:0]      ERR_SEL     = 2'b10;
    localparam logic [1:0]      ERR_STRAY   = 2'b11;
    localparam int unsigned     N_EU_U      = N_EU;
    localparam logic [TO_W-1:0] TO_LIM      = TO_W'(TIMEOUT - 1);

    state_t             state, nxt_state;
    logic [TO_W-1:0]    to_cnt;
    logic [SEL_W-1:0]   sel_q;
    logic               mem_q;
    logic               err_q;
    logic [1:0]         code_q;
    logic [CNT_W-1:0]   ret_q;

    logic [N_EU-1:0]    sel_oh;
    logic               to_hit;
    logic               waiting;
    logic               sel_illegal;
    logic               eu_hit;
    logic               eu_stray;
    logic               latch_dec;
    logic               do_retire;
    logic               set_err;
    logic [1:0]         nxt_code;

    // Decode latched channel select and handshake qualifiers.
    always_comb begin
        sel_oh = '0;
        for (int unsigned i = 0; i < N_EU_U; i++) begin
            sel_oh[i] = (32'(sel_q) == i);
        end
        sel_illegal = (32'(dec_eu_sel) >= N_EU_U);
        eu_hit      = |(ready_eu & sel_oh);
        eu_stray    = |(ready_eu & ~sel_oh);
        to_hit      = (to_cnt == TO_LIM);
        waiting     = (state == FETCH) || (state == DECODE) ||
                      (state == EXEC)  || (state == MEM);
    end

    // Next-state logic; a ready arriving on the limit cycle beats the timeout.
    always_comb begin
        nxt_state = state;
        latch_dec = 1'b0;
        do_retire = 1'b0;
        set_err   = 1'b0;
        nxt_code  = code_q;
        case (state)
            IDLE: begin
                if (run && (!step || go)) nxt_state = FETCH;
            end
            FETCH: begin
                if (ready_fcu) begin
                    nxt_state = DECODE;
                end else if (to_hit) begin
                    nxt_state = HALT;
                    set_err   = 1'b1;
                    nxt_code  = ERR_TIMEOUT;
                end
            end
            DECODE: begin
                if (ready_dec) begin
                    latch_dec = 1'b1;
                    if (sel_illegal) begin
                        nxt_state = HALT;
                        set_err   = 1'b1;
                        nxt_code  = ERR_SEL;
                    end else begin
                        nxt_state = EXEC;
                    end
                end else if (to_hit) begin
                    nxt_state = HALT;
                    set_err   = 1'b1;
                    nxt_code  = ERR_TIMEOUT;
                end
            end
            EXEC: begin
                if (eu_stray) begin
                    nxt_state = HALT;
                    set_err   = 1'b1;
                    nxt_code  = ERR_STRAY;
                end else if (eu_hit) begin
                    if (mem_q) nxt_state = MEM;
                    else       do_retire = 1'b1;
                end else if (to_hit) begin
                    nxt_state = HALT;
                    set_err   = 1'b1;
                    nxt_code  = ERR_TIMEOUT;
                end
            end
            MEM: begin
                if (ready_biu) begin
                    do_retire = 1'b1;
                end else if (to_hit) begin
                    nxt_state = HALT;
                    set_err   = 1'b1;
                    nxt_code  = ERR_TIMEOUT;
                end
            end
            HALT: begin
                nxt_state = HALT;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
        if (do_retire) nxt_state = (run && !step) ? FETCH : IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt_state;
    end

    // Phase timeout counter: restarts on every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  to_cnt <= '0;
        else if (nxt_state != state) to_cnt <= '0;
        else if (waiting)            to_cnt <= to_cnt + 1'b1;
    end

    // Latch decoder results for the execute and memory phases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q <= '0;
            mem_q <= 1'b0;
        end else if (latch_dec) begin
            sel_q <= dec_eu_sel;
            mem_q <= dec_mem;
        end
    end

    // Sticky error flag and code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q  <= 1'b0;
            code_q <= 2'b00;
        end else if (set_err) begin
            err_q  <= 1'b1;
            code_q <= nxt_code;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         ret_q <= '0;
        else if (do_retire) ret_q <= ret_q + 1'b1;
    end

    // Outputs decoded from registered state only.
    always_comb begin
        cs_fcu   = (state == FETCH);
        cs_dec   = (state == DECODE);
        cs_eu    = (state == EXEC) ? sel_oh : '0;
        cs_biu   = (state == MEM);
        busy     = (state != IDLE) && (state != HALT);
        err      = err_q;
        err_code = code_q;
        retired  = ret_q;
        state_o  = state;
    end

endmodule
